// File: rtl/accu_cpu_core.sv
// -----------------------------------------------------------------------------
// accu_cpu_core
//
// Multi-cycle accumulator CPU core. Each instruction runs FETCH -> EXEC, and
// LDM/STM add one or more MEM cycles that wait on an external data-memory
// handshake. HALT parks the core until reset. Program ROM and data RAM are
// external to the core.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   imem_addr   program address (the PC)
//   imem_data   16-bit instruction, combinational read of imem_addr
//   dmem_req    registered request, high exactly during MEM cycles
//   dmem_we     1 = write, 0 = read, valid with dmem_req
//   dmem_addr   data address, valid with dmem_req
//   dmem_wdata  write data (the accumulator)
//   dmem_rdata  read data, sampled on the ack cycle
//   dmem_ack    transfer complete; ignored outside MEM
//   acc         accumulator
//   carry       carry/borrow flag
//   zero        combinational (acc == 0)
//   halted      core is in HALT
// -----------------------------------------------------------------------------
module accu_cpu_core #(
    parameter int DATA_WIDTH      = 8,
    parameter int RF_DEPTH        = 4,
    parameter int PC_WIDTH        = 5,
    parameter int DMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [PC_WIDTH-1:0]        imem_addr,
    input  logic [15:0]                imem_data,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]      dmem_wdata,
    input  logic [DATA_WIDTH-1:0]      dmem_rdata,
    input  logic                       dmem_ack,
    output logic [DATA_WIDTH-1:0]      acc,
    output logic                       carry,
    output logic                       zero,
    output logic                       halted
);

    localparam int RW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDR  = 4'h2;
    localparam logic [3:0] OP_STR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_LDM  = 4'hA;
    localparam logic [3:0] OP_STM  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic [15:0]                ir_q, ir_d;
    logic [DATA_WIDTH-1:0]      acc_q, acc_d;
    logic                       carry_q, carry_d;
    logic                       req_q, req_d;
    logic                       we_q, we_d;
    logic [DMEM_ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [DATA_WIDTH-1:0]      rf_q [RF_DEPTH];
    logic                       rf_we;

    // Instruction field decode; the casts keep only the low operand bits.
    logic [3:0]                 opcode;
    logic [DATA_WIDTH-1:0]      imm;
    logic [RW-1:0]              rsel;
    logic [DMEM_ADDR_WIDTH-1:0] maddr;
    logic [PC_WIDTH-1:0]        target;
    logic [PC_WIDTH-1:0]        pc_inc;
    logic [DATA_WIDTH-1:0]      rf_rdata;
    logic [DATA_WIDTH-1:0]      alu_b;

    assign opcode   = ir_q[15:12];
    assign imm      = DATA_WIDTH'(ir_q[11:0]);
    assign rsel     = RW'(ir_q[11:0]);
    assign maddr    = DMEM_ADDR_WIDTH'(ir_q[11:0]);
    assign target   = PC_WIDTH'(ir_q[11:0]);
    assign pc_inc   = pc_q + PC_WIDTH'(1);
    assign rf_rdata = rf_q[rsel];
    assign alu_b    = (opcode == OP_ADDI) ? imm : rf_rdata;

    // Returns {carry, result}. Add/sub compute one bit wider so the top bit
    // is the carry-out (add) or the borrow (sub, set when a < b). Logic ops
    // pass the incoming carry through untouched.
    function automatic logic [DATA_WIDTH:0] alu_op(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic                  cin
    );
        logic [DATA_WIDTH:0] r;
        r = {cin, a};
        case (op)
            OP_ADD, OP_ADDI: r = {1'b0, a} + {1'b0, b};
            OP_SUB:          r = {1'b0, a} - {1'b0, b};
            OP_AND:          r = {cin, a & b};
            OP_OR:           r = {cin, a | b};
            OP_XOR:          r = {cin, a ^ b};
            default:         r = {cin, a};
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        req_d   = req_q;
        we_d    = we_q;
        daddr_d = daddr_q;
        rf_we   = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_d    = imem_data;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_NOP: ;
                    OP_LDI: acc_d = imm;
                    OP_LDR: acc_d = rf_rdata;
                    OP_STR: rf_we = 1'b1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI:
                        {carry_d, acc_d} = alu_op(opcode, acc_q, alu_b, carry_q);
                    OP_LDM, OP_STM: begin
                        // PC advances only once the transfer is acknowledged.
                        pc_d    = pc_q;
                        state_d = S_MEM;
                        req_d   = 1'b1;
                        we_d    = (opcode == OP_STM);
                        daddr_d = maddr;
                    end
                    OP_JMP: pc_d = target;
                    OP_JZ:  if (acc_q == '0) pc_d = target;
                    OP_JC:  if (carry_q) pc_d = target;
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                if (dmem_ack) begin
                    if (!we_q) acc_d = dmem_rdata;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            S_HALT: ;

            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            daddr_q <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            req_q   <= req_d;
            we_q    <= we_d;
            daddr_q <= daddr_d;
            if (rf_we) rf_q[rsel] <= acc_q;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = daddr_q;
    assign dmem_wdata = acc_q;
    assign acc        = acc_q;
    assign carry      = carry_q;
    assign zero       = (acc_q == '0);
    assign halted     = (state_q == S_HALT);

endmodule

// File: doc/accu_cpu_core.md
# accu_cpu_core

Parametrised multi-cycle accumulator CPU core, the successor to the fixed 8-bit single-cycle accumulator top. It adds configurable data width, register-file depth and PC width, and a FETCH/EXEC/MEM state machine. It also adds a handshaked external data-memory port, carry/zero flags, conditional jumps and HALT. Program ROM and data RAM sit outside the core; the core drives their addresses.

## Interface
Parameters:
- DATA_WIDTH, 8, accumulator/register/data width (4..12)
- RF_DEPTH, 4, register count, power of two, 2..16
- PC_WIDTH, 5, program address width
- DMEM_ADDR_WIDTH, 10, data-memory address width (≤12)

Ports (one clock; reset asynchronous, active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- imem_addr  out  PC_WIDTH  program address (= PC)
- imem_data  in  16  instruction, combinational read of imem_addr
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = write, 0 = read; valid with dmem_req
- dmem_addr  out  DMEM_ADDR_WIDTH  data address; valid with dmem_req
- dmem_wdata  out  DATA_WIDTH  write data (= acc)
- dmem_rdata  in  DATA_WIDTH  read data, sampled on the ack cycle
- dmem_ack  in  1  transfer complete
- acc  out  DATA_WIDTH  accumulator
- carry  out  1  carry/borrow flag
- zero  out  1  combinational (acc == 0)
- halted  out  1  core is in HALT

## Operation
- Instruction format: [15:12] opcode, [11:0] operand. imm = operand[DATA_WIDTH-1:0]. r = operand[log2(RF_DEPTH)-1:0]. addr = operand[DMEM_ADDR_WIDTH-1:0]. target = operand[PC_WIDTH-1:0].
- Opcodes:
  - 0 NOP
  - 1 LDI: acc←imm
  - 2 LDR: acc←RF[r]
  - 3 STR: RF[r]←acc
  - 4 ADD: {carry,acc}←acc+RF[r]
  - 5 SUB: acc←acc−RF[r], carry←(acc<RF[r])
  - 6 AND r
  - 7 OR r
  - 8 XOR r
  - 9 ADDI: {carry,acc}←acc+imm
  - A LDM: acc←mem[addr]
  - B STM: mem[addr]←acc
  - C JMP target
  - D JZ: jump if zero
  - E JC: jump if carry
  - F HALT
- carry changes only on ADD/SUB/ADDI. Logic ops and loads leave carry unchanged.
- Arithmetic is modulo 2^DATA_WIDTH; the carry-out is bit DATA_WIDTH of the unsigned sum.
- PC increments modulo 2^PC_WIDTH (wraps to 0). A taken jump loads target; a not-taken jump increments.
- States:
  - FETCH: IR←imem_data → EXEC.
  - EXEC: non-memory ops complete here, PC updates → FETCH. LDM/STM → MEM. HALT → HALT.
  - MEM: dmem_req=1 with dmem_we/dmem_addr/dmem_wdata held stable until dmem_ack is sampled high. On the ack edge: for LDM acc←dmem_rdata; PC+1 → FETCH.
  - HALT: absorbing. halted=1. Only rst leaves.
- dmem_req is registered, high exactly during MEM cycles, never outside MEM.
- dmem_ack outside MEM is ignored.
- RF has one write port, asynchronous reset to 0.

## Timing
- Reset values: PC=0, state=FETCH, IR=0, acc=0, carry=0, RF all 0, dmem_req=0, dmem_we=0, halted=0, zero=1. The reset takes effect immediately, not at the next edge.
- Non-memory instruction: 2 cycles (FETCH, EXEC). Results are visible after the EXEC edge.
- LDM/STM: 2 + n cycles, where n ≥ 1 is the number of MEM cycles up to and including the one with dmem_ack=1. An ack in the first MEM cycle gives 3 cycles.
- Reset during MEM: dmem_req drops immediately. A late ack after reset release is ignored (core is in FETCH).
- JZ uses zero as seen during EXEC, i.e. the result of the prior instruction.
- halted rises on the edge ending EXEC of HALT. imem_addr then holds at the HALT address + 0 (PC is not incremented).

## Test plan
- Reset: assert rst mid-run → acc=0x00, carry=0, zero=1, halted=0, dmem_req=0, imem_addr=0 without waiting for an edge.
- LDI 0xF0; ADDI 0x20 → acc=0x10, carry=1 after cycle 4. Then AND with RF[0]=0 → acc=0x00, zero=1, carry stays 1.
- LDI 0x05; STR r1; LDI 0x03; SUB r1 → acc=0xFE, carry=1. LDR r1 → acc=0x05, carry unchanged.
- LDI 0x55; STM 0x3A with ack delayed to the 4th MEM cycle → dmem_req high exactly 4 cycles, dmem_we=1, dmem_addr=0x3A, dmem_wdata=0x55, stable throughout. LDM 0x3A with rdata=0x55 and an immediate ack → acc=0x55 after 3 cycles.
- Branching:
  - NOP at address 31 (PC_WIDTH=5) → next imem_addr=0.
  - LDI 0; JZ 7 → imem_addr=7.
  - LDI 1; JZ 7 → PC+1.
  - JC with carry=1 → taken.
- HALT: fetch HALT at address 9 → halted=1, imem_addr stays 9 and dmem_req=0 for 20 cycles. rst → resumes at 0. rst during MEM with a later ack → no acc change.
